// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encodings,
// opcodes, datapath select codes and the packed control word.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. mem_ready exists only when
// MIPS_CTRL_MEM_WAIT_EN is defined.
interface mips_multicycle_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
`ifdef MIPS_CTRL_MEM_WAIT_EN
  logic                mem_ready;
`endif
  logic                pc_write;
  logic                branch;
  logic                iord;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_src;
  logic                illegal_op;

  // Datapath side drives the opcode (and memory ready) and consumes controls.
  modport master (
`ifdef MIPS_CTRL_MEM_WAIT_EN
    output mem_ready,
`endif
    output opcode,
    input  pc_write, branch, iord, mem_write, ir_write, reg_dst,
    input  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
    input  illegal_op
  );

  modport slave (
`ifdef MIPS_CTRL_MEM_WAIT_EN
    input  mem_ready,
`endif
    input  opcode,
    output pc_write, branch, iord, mem_write, ir_write, reg_dst,
    output mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
    output illegal_op
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Pure Moore output table: maps the FSM state to the datapath control word.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_FOUR;
      end
      S_DECODE:   ctrl_o.alu_src_b = ALUSRCB_IMMSH;
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
      end
      S_MEMRD:    ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_OP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
      end
      S_ADDIWB:   ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JUMP;
      end
      default:    ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main multi-cycle MIPS control FSM. Define MIPS_CTRL_MEM_WAIT_EN to stall
// FETCH/MEMRD/MEMWR on mem_ready.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned        STATE_W     = 4,
  parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_multicycle_ctrl_if.slave ctrl_if,
  output logic [STATE_W-1:0]    state_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl_raw, ctrl_out;
  logic   illegal;
  logic   mem_ready_w;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  assign mem_ready_w = ctrl_if.mem_ready;
`else
  assign mem_ready_w = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= state_e'(RESET_STATE);
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready_w) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl_if.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (ctrl_if.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready_w) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ready_w) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl_raw)
  );

  // Fetch writes wait for memory so the PC advances once; reset masks everything.
  always_comb begin
    ctrl_out = ctrl_raw;
    illegal  = 1'b0;
    if (state_q == S_FETCH && !mem_ready_w) begin
      ctrl_out.pc_write = 1'b0;
      ctrl_out.ir_write = 1'b0;
    end
    if (state_q == S_DECODE) illegal = !is_legal_op(ctrl_if.opcode);
    if (rst) begin
      ctrl_out = '0;
      illegal  = 1'b0;
    end
  end

  assign ctrl_if.pc_write   = ctrl_out.pc_write;
  assign ctrl_if.branch     = ctrl_out.branch;
  assign ctrl_if.iord       = ctrl_out.iord;
  assign ctrl_if.mem_write  = ctrl_out.mem_write;
  assign ctrl_if.ir_write   = ctrl_out.ir_write;
  assign ctrl_if.reg_dst    = ctrl_out.reg_dst;
  assign ctrl_if.mem_to_reg = ctrl_out.mem_to_reg;
  assign ctrl_if.reg_write  = ctrl_out.reg_write;
  assign ctrl_if.alu_src_a  = ctrl_out.alu_src_a;
  assign ctrl_if.alu_src_b  = ctrl_out.alu_src_b;
  assign ctrl_if.alu_op     = ctrl_out.alu_op;
  assign ctrl_if.pc_src     = ctrl_out.pc_src;
  assign ctrl_if.illegal_op = illegal;

  assign state_o = rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed and random
// instruction streams checked cycle by cycle against an instruction-level model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] stateO;
  int         vectors     = 0;
  int         miscompares = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(
    .STATE_W     (4),
    .RESET_STATE (4'd0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus.slave),
    .state_o (stateO)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] obsVec();
    return {bus.pc_write, bus.branch, bus.iord, bus.mem_write, bus.ir_write,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op};
  endfunction

  function automatic bit isLegal(input logic [5:0] op);
    return (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) ||
           (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
  endfunction

  // Expected control outputs for a given step of an instruction.
  function automatic logic [15:0] expOut(input int s, input bit ill, input bit rdy);
    logic pcW = 0, br = 0, iord = 0, memW = 0, irW = 0, regDst = 0;
    logic m2r = 0, regW = 0, srcA = 0, illOut = 0;
    logic [1:0] srcB = 0, aluOp = 0, pcSrc = 0;
    case (s)
      0: begin irW = rdy; pcW = rdy; srcB = 2'b01; end
      1: begin srcB = 2'b11; illOut = ill; end
      2: begin srcA = 1; srcB = 2'b10; end
      3: iord = 1;
      4: begin m2r = 1; regW = 1; end
      5: begin iord = 1; memW = 1; end
      6: begin srcA = 1; aluOp = 2'b10; end
      7: begin regDst = 1; regW = 1; end
      8: begin srcA = 1; aluOp = 2'b01; pcSrc = 2'b01; br = 1; end
      9: begin srcA = 1; srcB = 2'b10; end
      10: regW = 1;
      11: begin pcW = 1; pcSrc = 2'b10; end
      default: ;
    endcase
    return {pcW, br, iord, memW, irW, regDst, m2r, regW, srcA, srcB, aluOp, pcSrc, illOut};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input int s, input bit ill, input bit rdy);
    checkOutput({tag, " state"}, {12'h000, stateO}, 16'(s));
    checkOutput({tag, " outputs"}, obsVec(), expOut(s, ill, rdy));
  endtask

  // Runs one whole instruction from FETCH; fetchWait>=0 forces that many
  // not-ready cycles in FETCH when memory wait states are enabled.
  task automatic applyStimulus(input logic [5:0] op, input int fetchWait);
    int trace[$];
    bit ill;
    int pcWrites;
    ill = !isLegal(op);
    case (op)
      6'h23:   trace = '{0, 1, 2, 3, 4};
      6'h2B:   trace = '{0, 1, 2, 5};
      6'h00:   trace = '{0, 1, 6, 7};
      6'h08:   trace = '{0, 1, 9, 10};
      6'h04:   trace = '{0, 1, 8};
      6'h02:   trace = '{0, 1, 11};
      default: trace = '{0, 1};
    endcase
    pcWrites = 0;
    bus.opcode = op;
    foreach (trace[i]) begin
      int s;
      int waits;
      bit rdy;
      s = trace[i];
      waits = 0;
      do begin
        rdy = 1'b1;
`ifdef MIPS_CTRL_MEM_WAIT_EN
        if (s == 0 && fetchWait >= 0)          rdy = (waits >= fetchWait);
        else if (s == 0 || s == 3 || s == 5)   rdy = (waits >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.mem_ready = rdy;
`endif
        #1;
        checkCycle($sformatf("op%02h step%0d wait%0d", op, i, waits), s, ill, rdy);
        if (s == 0 && bus.pc_write === 1'b1) pcWrites++;
        @(posedge clk);
        #1;
        waits++;
      end while (!rdy);
    end
`ifdef MIPS_CTRL_MEM_WAIT_EN
    if (fetchWait >= 0) checkOutput("pc_write_once", 16'(pcWrites), 16'd1);
`endif
  endtask

  initial begin
    logic [5:0] legalOps [6];
    legalOps = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};

    // Reset held for two edges: everything reads zero.
    bus.opcode = 6'h15;
`ifdef MIPS_CTRL_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("reset state", {12'h000, stateO}, 16'h0000);
      checkOutput("reset outputs", obsVec(), 16'h0000);
    end
    rst = 1'b0;

    // Directed: lw, R-type, beq, illegal, sw, addi, j.
    applyStimulus(6'h23, -1);
    applyStimulus(6'h00, -1);
    applyStimulus(6'h04, -1);
    applyStimulus(6'h3F, -1);
    applyStimulus(6'h2B, -1);
    applyStimulus(6'h08, -1);
    applyStimulus(6'h02, -1);

    // sw abandoned by reset during MEMADR.
    bus.opcode = 6'h2B;
    #1; checkCycle("midrst fetch", 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    #1; checkCycle("midrst decode", 1, 1'b0, 1'b1);
    @(posedge clk); #1;
    #1; checkCycle("midrst memadr", 2, 1'b0, 1'b1);
    rst = 1'b1;
    #1; checkOutput("midrst forced outputs", obsVec(), 16'h0000);
    @(posedge clk); #1;
    checkOutput("midrst during reset", obsVec(), 16'h0000);
    rst = 1'b0;
    #1; checkCycle("midrst after", 0, 1'b0, 1'b1);

`ifdef MIPS_CTRL_MEM_WAIT_EN
    applyStimulus(6'h00, 3);
`endif

    // Random instruction stream, occasionally with arbitrary opcodes.
    repeat (40) begin
      int pick;
      logic [5:0] op;
      pick = $urandom_range(0, 7);
      if (pick < 6) op = legalOps[pick];
      else          op = 6'($urandom_range(0, 63));
      applyStimulus(op, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
